accum_diff: RTL and testbench
=============================

Name: accum_diff

Overview:
- Reader side of the running-sum accumulator stream: takes the 11-bit accumulated sum sampled once per accepted beat and recovers the 5-bit increments that produced it.
- Sits downstream of the accumulator.
- Checks each recovered increment for range, counts violations, and buffers increments in a small FIFO with a valid/ready output toward the consumer logic.

Parameters:
- SUM_W, 11, width of incoming accumulated sum (modulo-2^SUM_W arithmetic)
- INC_W, 5, width of recovered increment; legal increment range 0..2^INC_W-1
- DEPTH, 4, output FIFO depth in entries (power of two, >=2)
- ERR_W, 8, width of saturating range-error counter

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_sum carries a sample
- in_ready  output  1  block accepts sample this cycle
- in_sum  input  SUM_W  accumulated sum sample
- resync  input  1  synchronous: drop baseline, flush FIFO
- out_valid  output  1  out_inc holds a buffered increment
- out_ready  input  1  consumer takes out_inc this cycle
- out_inc  output  INC_W  recovered increment at FIFO head
- err_pulse  output  1  one-cycle strobe on range violation
- err_cnt  output  ERR_W  saturating count of range violations

Behaviour:
- Reset (async, rst=1):
  - state=SYNC, FIFO empty, baseline=0.
  - out_valid=0, out_inc=0, err_pulse=0, err_cnt=0.
  - in_ready=1 once rst deasserts.
- Handshake:
  - Input beat accepted when in_valid & in_ready.
  - Output beat consumed when out_valid & out_ready.
  - in_ready = !resync & (state==SYNC | !fifo_full).
  - in_ready does not depend on in_valid or in_sum.
- State SYNC:
  - Accepted sample loads baseline=in_sum; nothing pushed.
  - Transition to RUN.
- State RUN, accepted sample:
  - diff = (in_sum - baseline) mod 2^SUM_W, SUM_W-bit unsigned; baseline <= in_sum.
  - If diff <= 2^INC_W-1: push diff[INC_W-1:0] into FIFO.
  - If diff > 2^INC_W-1: no push; err_pulse=1 next cycle for exactly one cycle; err_cnt += 1, saturating at 2^ERR_W-1. State stays RUN.
  - Wrap-around is legal: the sum rolling past 2^SUM_W-1 yields a correct small diff.
- resync=1:
  - Next cycle: state=SYNC, FIFO empty, out_valid=0.
  - No input accepted during the resync cycle.
  - Overrides any simultaneous pop; a pop in that cycle is discarded.
  - err_cnt is unaffected.
- FIFO:
  - Registered storage; push-to-out_valid latency is 1 cycle.
  - out_valid = !empty; out_inc = head entry when out_valid=1, else 0.
  - Full: in_ready=0 in RUN. No push-while-full, even when popping the same cycle; in_ready reasserts the cycle after a pop.
  - Simultaneous push and pop when not full: both happen, count unchanged.
- Reset mid-operation: immediate return to reset values regardless of state or FIFO contents.

Test Plan:
- Reset, out_ready=1, in_valid=1 with sums 0,5,36,67 -> first sample is baseline with no output; out_inc sequence 5,31,31; err_cnt=0.
- Baseline 2040, then sum 3 -> diff (3-2040) mod 2048 = 11; out_inc=11, no error.
- Baseline 100, then 140, then 150 -> no push for 140; err_pulse high one cycle; err_cnt=1; next out_inc=10 (150-140).
- Backpressure: out_ready=0, baseline 0, then sums 1,3,6,10,15 -> four accepted, in_ready=0 on the fifth, out_inc=1. Raise out_ready -> pops 1,2,3,4; fifth sample accepted after the first pop, and 5 is popped last.
- FIFO holding 2 entries, resync pulse -> out_valid=0 next cycle; next accepted sample is baseline only; err_cnt unchanged. Force 260 range errors -> err_cnt saturates at 255.
- Assert rst asynchronously mid-burst, FIFO 3 entries full-ish -> outputs return to reset values immediately; after release, first sample is treated as baseline.

Source files
------------

// File: rtl/accum_diff.sv
// Recovers per-beat increments from a running-sum stream, range-checks them
// and buffers the good ones in a small FIFO toward the consumer.
module accum_diff #(
    parameter int unsigned SUM_W = 11,
    parameter int unsigned INC_W = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             resync,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INC_W-1:0] out_inc,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [SUM_W-1:0]   baseline;
    logic [INC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               full;
    logic               accept;
    logic               pop;
    logic               push;
    logic               range_err;
    logic               in_range;
    logic [SUM_W-1:0]   diff;

    // Modulo subtraction makes a rollover of the upstream sum come out as a small diff.
    assign diff      = in_sum - baseline;
    assign in_range  = (diff >> INC_W) == '0;

    assign full      = (count == CNT_W'(DEPTH));
    assign in_ready  = !rst && !resync && ((state == SYNC) || !full);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !resync;
    assign push      = accept && (state == RUN) && in_range;
    assign range_err = accept && (state == RUN) && !in_range;
    assign out_inc   = out_valid ? mem[rd_ptr] : '0;

    // Control, pointers and error accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            baseline  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else if (resync) begin
            state     <= SYNC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= range_err;
            if (range_err && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (accept) begin
                baseline <= in_sum;
                state    <= RUN;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; out_inc is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= diff[INC_W-1:0];
        end
    end

endmodule

// File: tb/tb_accum_diff.sv
// Randomized scoreboard bench for accum_diff against a queue-based reference model.
module tb_accum_diff;

    localparam int unsigned SUM_W = 11;
    localparam int unsigned INC_W = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum = '0;
    logic             resync = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [INC_W-1:0] out_inc;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    always #5 clk = ~clk;

    accum_diff #(.SUM_W(SUM_W), .INC_W(INC_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .resync(resync),
        .out_valid(out_valid), .out_ready(out_ready), .out_inc(out_inc),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected increments in order, plus occupancy and error state.
    int               exp_q[$];
    bit               m_run   = 0;
    logic [SUM_W-1:0] m_base  = '0;
    int               m_occ   = 0;
    int               m_err   = 0;
    bit               m_pulse = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every consumed output beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !resync) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_inc_unexpected: got %0d expected no output at %0t", out_inc, $time);
            end else begin
                chk("out_inc", out_inc, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit v, input logic [SUM_W-1:0] s, input bit ordy,
                        input bit rs, output bit acc);
        logic [SUM_W-1:0] d;
        bit exp_rdy;
        bit pop;
        in_valid  = v;
        in_sum    = s;
        out_ready = ordy;
        resync    = rs;
        @(negedge clk);
        exp_rdy = !rs && (!m_run || m_occ < int'(DEPTH));
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_occ > 0);
        if (m_occ == 0) chk("out_inc_idle", out_inc, 0);
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_cnt", err_cnt, m_err);
        acc     = v && exp_rdy;
        pop     = (m_occ > 0) && ordy && !rs;
        m_pulse = 0;
        if (rs) begin
            m_run = 0;
            m_occ = 0;
            exp_q.delete();
        end else begin
            if (acc) begin
                if (m_run) begin
                    d = s - m_base;
                    if (int'(d) < (1 << INC_W)) begin
                        exp_q.push_back(int'(d));
                        m_occ++;
                    end else begin
                        m_pulse = 1;
                        if (m_err < (1 << ERR_W) - 1) m_err++;
                    end
                end
                m_run  = 1;
                m_base = s;
            end
            if (pop) m_occ--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SUM_W-1:0] s, input bit ordy);
        bit acc;
        int tries;
        tries = 0;
        acc   = 0;
        while (!acc && tries < 64) begin
            step(1'b1, s, ordy, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: sum %0d not accepted within %0d cycles", s, tries);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, acc);
    endtask

    task automatic do_resync();
        bit acc;
        step(1'b1, '0, 1'b1, 1'b1, acc);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inc", out_inc, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        m_run = 0; m_occ = 0; m_err = 0; m_pulse = 0; m_base = '0;
        exp_q.delete();
        in_valid = 1'b0; out_ready = 1'b0; resync = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit acc;
        logic [SUM_W-1:0] cur;
        bit rs;
        bit v;
        logic [SUM_W-1:0] s;

        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_out_inc", out_inc, 0);
        chk("init_err_pulse", err_pulse, 0);
        chk("init_err_cnt", err_cnt, 0);
        rst = 1'b0;

        // Basic recovery: expect 5,31,31.
        send(11'd0, 1'b1); send(11'd5, 1'b1); send(11'd36, 1'b1); send(11'd67, 1'b1);
        idle(3, 1'b1);

        // Wrap-around: 2040 -> 3 gives 11.
        do_resync();
        send(11'd2040, 1'b1); send(11'd3, 1'b1);
        idle(3, 1'b1);

        // Range error on 140, then 10.
        do_resync();
        send(11'd100, 1'b1); send(11'd140, 1'b1); send(11'd150, 1'b1);
        idle(3, 1'b1);

        // Backpressure: four fill the FIFO, fifth waits for a pop.
        do_resync();
        send(11'd0, 1'b0); send(11'd1, 1'b0); send(11'd3, 1'b0);
        send(11'd6, 1'b0); send(11'd10, 1'b0);
        step(1'b1, 11'd15, 1'b0, 1'b0, acc);
        step(1'b1, 11'd15, 1'b0, 1'b0, acc);
        send(11'd15, 1'b1);
        idle(6, 1'b1);

        // Resync with two entries queued, then rebaseline.
        do_resync();
        send(11'd0, 1'b0); send(11'd5, 1'b0); send(11'd9, 1'b0);
        do_resync();
        idle(2, 1'b1);
        send(11'd50, 1'b1); send(11'd52, 1'b1);
        idle(3, 1'b1);

        // Saturate the error counter.
        cur = 11'd52;
        for (int i = 0; i < 262; i++) begin
            cur = cur + 11'd100;
            send(cur, 1'b1);
        end
        idle(2, 1'b1);

        // Asynchronous reset with three entries buffered.
        send(cur + 11'd1, 1'b0); send(cur + 11'd2, 1'b0); send(cur + 11'd3, 1'b0);
        async_reset();
        send(11'd500, 1'b1); send(11'd503, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic.
        cur = 11'd503;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) s = cur + SUM_W'($urandom_range(32, 2000));
            else                           s = cur + SUM_W'($urandom_range(0, 31));
            step(v, s, 1'($urandom_range(0, 1)), rs, acc);
            if (acc) cur = s;
        end

        idle(8, 1'b1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
